// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one line-wide backing-memory port between the I-cache and D-cache
// miss paths. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration;
// without it, D has fixed priority bounded by a starvation limit for I.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_icache_req,
    input  logic              in_icache_we,
    input  logic [ADDR_W-1:0] in_icache_addr,
    input  logic [LINE_W-1:0] in_icache_wdata,
    output logic [LINE_W-1:0] out_icache_rdata,
    output logic              out_icache_ready,
    input  logic              in_dcache_req,
    input  logic              in_dcache_we,
    input  logic [ADDR_W-1:0] in_dcache_addr,
    input  logic [LINE_W-1:0] in_dcache_wdata,
    output logic [LINE_W-1:0] out_dcache_rdata,
    output logic              out_dcache_ready,
    output logic              out_mem_read_en,
    output logic              out_mem_write_en,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [LINE_W-1:0] out_mem_wdata,
    input  logic [LINE_W-1:0] in_mem_rdata,
    input  logic              in_mem_ready,
    output logic [1:0]        out_grant
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Clears the byte-offset bits so the memory always sees a line address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

    logic [1:0]        state;
    logic              owner_d;     // 1 = D-cache owns the port, 0 = I-cache
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic [LINE_W-1:0] rdata_i;
    logic [LINE_W-1:0] rdata_d;
    logic              any_req;
    logic              pick_d;

`ifdef MEM_ARB_RR_EN
    logic rr_last_d;                // side granted most recently (1 = D)
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt;   // consecutive D grants while I waited
`endif

    // Winner selection among the current requests (only consumed in IDLE).
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        pick_d  = 1'b0;
        any_req = in_icache_req | in_dcache_req;
`ifdef MEM_ARB_RR_EN
        pick_d  = in_dcache_req & (~in_icache_req | ~rr_last_d);
`else
        pick_d  = in_dcache_req & (~in_icache_req | (starve_cnt != STARVE_MAX));
`endif
    end

    // Transaction FSM: latch the winner's request, issue, wait, complete.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            // NOTE: the line registers are plain flops (not a RAM), so they are reset to keep outputs at 0.
            rdata_i   <= '0;
            rdata_d   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_d   <= pick_d;
                        lat_we    <= pick_d ? in_dcache_we    : in_icache_we;
                        lat_addr  <= (pick_d ? in_dcache_addr : in_icache_addr) & LINE_MASK;
                        lat_wdata <= pick_d ? in_dcache_wdata : in_icache_wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (in_mem_ready) begin
                        if (!lat_we) begin
                            if (owner_d) rdata_d <= in_mem_rdata;
                            else         rdata_i <= in_mem_rdata;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin history: remember which side won the latest grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_d <= 1'b1;
        end else if (state == S_IDLE && any_req) begin
            rr_last_d <= pick_d;
        end
    end
`else
    // Starvation counter: counts D grants that bypass a waiting I request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!in_icache_req) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (pick_d) starve_cnt <= starve_cnt + 1'b1;
            else        starve_cnt <= '0;
        end
    end
`endif

    // Memory-side strobes last exactly the ISSUE cycle; address/data held from the latch.
    assign out_mem_read_en  = (state == S_ISSUE) & ~lat_we;
    assign out_mem_write_en = (state == S_ISSUE) &  lat_we;
    assign out_mem_addr     = lat_addr;
    assign out_mem_wdata    = lat_wdata;

    // Completion routed only to the owner; grant is one-hot {D,I} outside IDLE.
    assign out_icache_ready = (state == S_DONE) & ~owner_d;
    assign out_dcache_ready = (state == S_DONE) &  owner_d;
    assign out_icache_rdata = rdata_i;
    assign out_dcache_rdata = rdata_d;
    assign out_grant        = (state == S_IDLE) ? 2'b00 : {owner_d, ~owner_d};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a 10-cycle line memory model.
// Build with MEM_ARB_RR_EN defined to exercise the round-robin variant.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int LAT    = 10;
`ifdef MEM_ARB_RR_EN
    localparam int I_TARGET = 2;
`else
    localparam int I_TARGET = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_icache_req, in_icache_we;
    logic [ADDR_W-1:0] in_icache_addr;
    logic [LINE_W-1:0] in_icache_wdata, out_icache_rdata;
    logic              out_icache_ready;
    logic              in_dcache_req, in_dcache_we;
    logic [ADDR_W-1:0] in_dcache_addr;
    logic [LINE_W-1:0] in_dcache_wdata, out_dcache_rdata;
    logic              out_dcache_ready;
    logic              out_mem_read_en, out_mem_write_en;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [LINE_W-1:0] out_mem_wdata;
    logic [LINE_W-1:0] in_mem_rdata;
    logic              in_mem_ready;
    logic [1:0]        out_grant;

    logic model_ready;
    logic stray_ready;
    assign in_mem_ready = model_ready | stray_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .in_icache_req(in_icache_req), .in_icache_we(in_icache_we),
        .in_icache_addr(in_icache_addr), .in_icache_wdata(in_icache_wdata),
        .out_icache_rdata(out_icache_rdata), .out_icache_ready(out_icache_ready),
        .in_dcache_req(in_dcache_req), .in_dcache_we(in_dcache_we),
        .in_dcache_addr(in_dcache_addr), .in_dcache_wdata(in_dcache_wdata),
        .out_dcache_rdata(out_dcache_rdata), .out_dcache_ready(out_dcache_ready),
        .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .in_mem_rdata(in_mem_rdata), .in_mem_ready(in_mem_ready),
        .out_grant(out_grant)
    );

    // Memory model: unwritten lines read back as their own address repeated 4 times.
    logic [LINE_W-1:0] mem_arr [logic [11:0]];
    logic              m_busy;
    int                m_cnt;

    function automatic logic [LINE_W-1:0] default_line(input logic [11:0] idx);
        logic [31:0] a;
        a = {16'h0, idx, 4'h0};
        return {4{a}};
    endfunction

    // Memory: capture on issue strobe, complete LAT cycles later; shares the DUT reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy       <= 1'b0;
            m_cnt        <= 0;
            model_ready  <= 1'b0;
            in_mem_rdata <= '0;
        end else begin
            model_ready <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    model_ready <= 1'b1;
                    m_busy      <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end else if (out_mem_read_en || out_mem_write_en) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                if (out_mem_write_en)
                    mem_arr[out_mem_addr[15:4]] = out_mem_wdata;
                else
                    in_mem_rdata <= mem_arr.exists(out_mem_addr[15:4]) ?
                                    mem_arr[out_mem_addr[15:4]] : default_line(out_mem_addr[15:4]);
            end
        end
    end

    // Monitor (negedge): pulse counts, issue address, hold stability, grant order.
    int                rd_pulses = 0, wr_pulses = 0, i_rdy = 0, d_rdy = 0, unstable = 0;
    logic [ADDR_W-1:0] iss_addr = '0;
    logic [LINE_W-1:0] iss_wdata = '0;
    bit                mon_busy = 1'b0;
    logic [1:0]        prev_grant = 2'b00;
    logic [1:0]        grant_log[$];

    always @(negedge clk) begin
        if (reset) mon_busy = 1'b0;
        if (out_mem_read_en)  rd_pulses++;
        if (out_mem_write_en) wr_pulses++;
        if (out_mem_read_en || out_mem_write_en) begin
            iss_addr  = out_mem_addr;
            iss_wdata = out_mem_wdata;
            mon_busy  = 1'b1;
        end else if (mon_busy) begin
            if (out_mem_addr !== iss_addr || out_mem_wdata !== iss_wdata) unstable++;
            if (in_mem_ready) mon_busy = 1'b0;
        end
        if (out_icache_ready) i_rdy++;
        if (out_dcache_ready) d_rdy++;
        if (out_grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(out_grant);
        prev_grant = out_grant;
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        rd_pulses = 0; wr_pulses = 0; i_rdy = 0; d_rdy = 0; unstable = 0;
        grant_log.delete();
    endtask

    // Waits (bounded) for the side's ready pulse, grabs rdata, drops that side's request.
    task automatic wait_ready(input bit side_d, input string tag, output logic [LINE_W-1:0] rd);
        bit seen;
        seen = 1'b0;
        rd   = '0;
        for (int n = 0; n < 60; n++) begin
            cycles(1);
            if (side_d ? out_dcache_ready : out_icache_ready) begin
                seen = 1'b1;
                rd   = side_d ? out_dcache_rdata : out_icache_rdata;
                if (side_d) in_dcache_req = 1'b0;
                else        in_icache_req = 1'b0;
                break;
            end
        end
        check({tag, "_seen"}, LINE_W'(seen), LINE_W'(1));
    endtask

    initial begin
        logic [LINE_W-1:0] rd_i, rd_d;
        logic [LINE_W-1:0] a5_line;
        int                seen_i;
        bit                done_i, done_d;

        a5_line         = {16{8'hA5}};
        reset           = 1'b1;
        stray_ready     = 1'b0;
        in_icache_req   = 1'b0; in_icache_we = 1'b0; in_icache_addr = '0; in_icache_wdata = '0;
        in_dcache_req   = 1'b0; in_dcache_we = 1'b0; in_dcache_addr = '0; in_dcache_wdata = '0;

        // Reset state: every output low.
        #1;
        check("rst_grant",    LINE_W'(out_grant), '0);
        check("rst_rd_en",    LINE_W'(out_mem_read_en), '0);
        check("rst_wr_en",    LINE_W'(out_mem_write_en), '0);
        check("rst_rdy",      LINE_W'({out_icache_ready, out_dcache_ready}), '0);
        check("rst_addr",     LINE_W'(out_mem_addr), '0);
        check("rst_wdata",    out_mem_wdata, '0);
        cycles(2);
        reset = 1'b0;
        cycles(2);

        // I-cache read of an unaligned address.
        clear_counts();
        in_icache_req = 1'b1; in_icache_we = 1'b0; in_icache_addr = 32'h1004;
        wait_ready(1'b0, "i_rd", rd_i);
        cycles(3);
        check("i_rd_data",    rd_i, {4{32'h0000_1000}});
        check("i_rd_pulses",  LINE_W'(rd_pulses), LINE_W'(1));
        check("i_rd_wpulses", LINE_W'(wr_pulses), LINE_W'(0));
        check("i_rd_addr",    LINE_W'(iss_addr), LINE_W'(32'h1000));
        check("i_rd_irdy",    LINE_W'(i_rdy), LINE_W'(1));
        check("i_rd_drdy",    LINE_W'(d_rdy), LINE_W'(0));
        check("i_rd_grant",   LINE_W'(grant_log[0]), LINE_W'(2'b01));

        // D-cache line write, then read it back through the I side.
        clear_counts();
        in_dcache_req = 1'b1; in_dcache_we = 1'b1; in_dcache_addr = 32'h2000; in_dcache_wdata = a5_line;
        wait_ready(1'b1, "d_wr", rd_d);
        cycles(3);
        check("d_wr_wpulses", LINE_W'(wr_pulses), LINE_W'(1));
        check("d_wr_rpulses", LINE_W'(rd_pulses), LINE_W'(0));
        check("d_wr_addr",    LINE_W'(iss_addr), LINE_W'(32'h2000));
        check("d_wr_wdata",   iss_wdata, a5_line);
        check("d_wr_stable",  LINE_W'(unstable), LINE_W'(0));
        check("d_wr_drdy",    LINE_W'(d_rdy), LINE_W'(1));
        check("d_wr_irdy",    LINE_W'(i_rdy), LINE_W'(0));
        check("d_wr_rdhold",  rd_d, '0);
        in_icache_req = 1'b1; in_icache_we = 1'b0; in_icache_addr = 32'h2000;
        wait_ready(1'b0, "i_rb", rd_i);
        cycles(3);
        check("i_rb_data",    rd_i, a5_line);

        // Simultaneous requests: D first, then I.
        clear_counts();
        in_icache_req = 1'b1; in_icache_we = 1'b0; in_icache_addr = 32'h3000;
        in_dcache_req = 1'b1; in_dcache_we = 1'b0; in_dcache_addr = 32'h4000;
        done_i = 1'b0; done_d = 1'b0;
        for (int n = 0; n < 100 && !(done_i && done_d); n++) begin
            cycles(1);
            if (out_icache_ready) begin rd_i = out_icache_rdata; in_icache_req = 1'b0; done_i = 1'b1; end
            if (out_dcache_ready) begin rd_d = out_dcache_rdata; in_dcache_req = 1'b0; done_d = 1'b0 | 1'b1; end
        end
        cycles(3);
        check("sim_done",     LINE_W'({done_d, done_i}), LINE_W'(2'b11));
        check("sim_nlog",     LINE_W'(grant_log.size()), LINE_W'(2));
        check("sim_first",    LINE_W'(grant_log[0]), LINE_W'(2'b10));
        check("sim_second",   LINE_W'(grant_log[1]), LINE_W'(2'b01));
        check("sim_idata",    rd_i, {4{32'h0000_3000}});
        check("sim_ddata",    rd_d, {4{32'h0000_4000}});

        // Both held continuously from a fresh reset.
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(2);
        clear_counts();
        in_dcache_req = 1'b1; in_dcache_we = 1'b0; in_dcache_addr = 32'h5000;
        in_icache_req = 1'b1; in_icache_we = 1'b0; in_icache_addr = 32'h6000;
        seen_i = 0;
        for (int n = 0; n < 300 && seen_i < I_TARGET; n++) begin
            cycles(1);
            if (out_icache_ready) seen_i++;
        end
        in_dcache_req = 1'b0;
        in_icache_req = 1'b0;
        cycles(20);
        check("hold_i_seen",  LINE_W'(seen_i), LINE_W'(I_TARGET));
`ifdef MEM_ARB_RR_EN
        check("rr_nlog",      LINE_W'(grant_log.size()), LINE_W'(3));
        check("rr_g0",        LINE_W'(grant_log[0]), LINE_W'(2'b01));
        check("rr_g1",        LINE_W'(grant_log[1]), LINE_W'(2'b10));
        check("rr_g2",        LINE_W'(grant_log[2]), LINE_W'(2'b01));
`else
        check("stv_nlog",     LINE_W'(grant_log.size()), LINE_W'(5));
        for (int k = 0; k < 4; k++)
            check($sformatf("stv_d%0d", k), LINE_W'(grant_log[k]), LINE_W'(2'b10));
        check("stv_i",        LINE_W'(grant_log[4]), LINE_W'(2'b01));
`endif

        // Memory ready while idle must be ignored.
        clear_counts();
        stray_ready = 1'b1;
        cycles(1);
        stray_ready = 1'b0;
        cycles(4);
        check("stray_grant",  LINE_W'(out_grant), '0);
        check("stray_rdy",    LINE_W'(i_rdy + d_rdy), '0);
        check("stray_issue",  LINE_W'(rd_pulses + wr_pulses), '0);

        // Reset during WAIT aborts the transaction.
        clear_counts();
        in_icache_req = 1'b1; in_icache_we = 1'b0; in_icache_addr = 32'h1000;
        cycles(5);
        check("abt_in_wait",  LINE_W'(out_grant), LINE_W'(2'b01));
        reset = 1'b1;
        in_icache_req = 1'b0;
        #1;
        check("abt_grant",    LINE_W'(out_grant), '0);
        check("abt_strobes",  LINE_W'({out_mem_read_en, out_mem_write_en}), '0);
        check("abt_addr",     LINE_W'(out_mem_addr), '0);
        check("abt_irdata",   out_icache_rdata, '0);
        cycles(2);
        reset = 1'b0;
        cycles(20);
        check("abt_no_rdy",   LINE_W'(i_rdy + d_rdy), '0);
        in_dcache_req = 1'b1; in_dcache_we = 1'b0; in_dcache_addr = 32'h100C;
        wait_ready(1'b1, "abt_next", rd_d);
        cycles(3);
        check("abt_next_data", rd_d, {4{32'h0000_1000}});
        check("abt_next_drdy", LINE_W'(d_rdy), LINE_W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
